// File: rtl/synch_bin_down_count_pkg.sv
// Shared types and default sizing for the loadable down-counter/timer.
package synch_bin_down_count_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned NBITS_DEFAULT    = 4;
  localparam int unsigned PRESCALE_DEFAULT = 4;

endpackage

// File: rtl/synch_bin_down_count_prescaler.sv
// Prescaler for the down-counter: pulses tick_o on every PRESCALE-th enabled cycle.
module synch_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic ena_i,
  output logic tick_o
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = ena_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (ena_i) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/synch_bin_down_count.sv
// Loadable synchronous down-counter/timer with one-cycle tc pulse and optional auto-reload.
// Optional prescaler enabled by defining SYNCH_BIN_DOWN_COUNT_PRESCALE_EN.
module synch_bin_down_count
  import synch_bin_down_count_pkg::*;
#(
  parameter int unsigned Nbits    = NBITS_DEFAULT,
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [Nbits-1:0] load_val,
  input  logic             reload,
  output logic [Nbits-1:0] counter,
  output logic             tc,
  output logic             busy
);

  if (PRESCALE < 2) begin : g_prescale_range
    $fatal(1, "PRESCALE must be at least 2");
  end

  state_e           state_q, state_d;
  logic [Nbits-1:0] cnt_q, cnt_d;
  logic [Nbits-1:0] rel_q, rel_d;
  logic             tc_q, tc_d;
  logic             step;

`ifdef SYNCH_BIN_DOWN_COUNT_PRESCALE_EN
  logic presc_ena, presc_clr;

  // Held clear outside RUN so a fresh count always starts a full prescale period.
  assign presc_ena = ena && (state_q == RUN) && !load;
  assign presc_clr = load || (state_q != RUN);

  synch_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (presc_clr),
    .ena_i (presc_ena),
    .tick_o(step)
  );
`else
  assign step = ena;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = load_val;
      rel_d   = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && step) begin
      if (cnt_q == Nbits'(1)) begin
        tc_d = 1'b1;
        if (reload) begin
          cnt_d = rel_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - Nbits'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      tc_q    <= tc_d;
    end
  end

  assign counter = cnt_q;
  assign tc      = tc_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_synch_bin_down_count.sv
// Directed scoreboard bench for synch_bin_down_count.
module tb_synch_bin_down_count;

  localparam int unsigned NB = 4;
  localparam int unsigned PS = 4;

  typedef struct packed {
    logic [NB-1:0] cnt;
    logic          tc;
    logic          busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          load;
  logic [NB-1:0] load_val;
  logic          reload;
  logic [NB-1:0] counter;
  logic          tc;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int tc_seen = 0;

  exp_t sb_q[$];

  int m_cnt = 0;
  int m_rel = 0;
  int m_pre = 0;
  bit m_run = 0;
  bit m_tc  = 0;

  synch_bin_down_count #(
    .Nbits   (NB),
    .PRESCALE(PS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .load    (load),
    .load_val(load_val),
    .reload  (reload),
    .counter (counter),
    .tc      (tc),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_pre = 0; m_run = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int lv, input bit rl);
    bit fire;
    m_tc = 0;
    fire = 0;
    if (l) begin
      m_cnt = lv;
      m_rel = lv;
      m_run = (lv != 0);
      m_pre = 0;
    end else if (m_run && e) begin
`ifdef SYNCH_BIN_DOWN_COUNT_PRESCALE_EN
      if (m_pre == PS - 1) begin
        m_pre = 0;
        fire  = 1;
      end else begin
        m_pre++;
      end
`else
      fire = 1;
`endif
      if (fire) begin
        if (m_cnt == 1) begin
          m_tc = 1;
          if (rl) m_cnt = m_rel;
          else begin
            m_cnt = 0;
            m_run = 0;
          end
        end else begin
          m_cnt--;
        end
      end
    end
    if (!m_run) m_pre = 0;
  endtask

  task automatic compare(input string tag);
    exp_t ex;
    ex = sb_q.pop_front();
    checks++;
    assert (counter === ex.cnt) else begin
      errors++;
      $error("FAIL %s counter got %0d want %0d", tag, counter, ex.cnt);
    end
    checks++;
    assert (tc === ex.tc) else begin
      errors++;
      $error("FAIL %s tc got %b want %b", tag, tc, ex.tc);
    end
    checks++;
    assert (busy === ex.busy) else begin
      errors++;
      $error("FAIL %s busy got %b want %b", tag, busy, ex.busy);
    end
    if (tc === 1'b1) tc_seen++;
  endtask

  task automatic step(input bit e, input bit l, input int lv, input bit rl, input string tag);
    ena      = e;
    load     = l;
    load_val = NB'(lv);
    reload   = rl;
    model_edge(e, l, lv, rl);
    sb_q.push_back('{cnt: NB'(m_cnt), tc: m_tc, busy: m_run});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; load = 1'b1; load_val = NB'(7); reload = 1'b0;
    model_reset();

    // 1: reset held 50 ns with load and ena asserted
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{cnt: '0, tc: 1'b0, busy: 1'b0});
      @(posedge clk);
      #1;
      compare("reset_hold");
    end
    rst = 1'b1;
    step(0, 0, 0, 0, "reset_release");

    // 2: one-shot of 5
    step(1, 1, 5, 0, "oneshot_load");
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, "oneshot_run");

    // 3: auto-reload of 3 for 12 enabled cycles
    step(1, 1, 3, 1, "reload_load");
    tc_seen = 0;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, "reload_run");
`ifndef SYNCH_BIN_DOWN_COUNT_PRESCALE_EN
    check_count("reload_tc_pulses", tc_seen, 4);
`endif

    // 4: enable gaps, load 4
    step(1, 1, 4, 0, "gap_load");
    tc_seen = 0;
    for (int i = 0; i < 10; i++) step((i % 2) == 0, 0, 0, 0, "gap_run");
`ifndef SYNCH_BIN_DOWN_COUNT_PRESCALE_EN
    check_count("gap_tc_pulses", tc_seen, 1);
`endif

    // 5a: load on terminal edge wins
    step(1, 1, 2, 0, "coll_load2");
    step(1, 0, 0, 0, "coll_dec");
    step(1, 1, 9, 0, "coll_load9");
    step(1, 0, 0, 0, "coll_after");

    // 5b: load of zero goes idle without tc
    step(1, 1, 0, 1, "load_zero");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, "zero_idle");

    // 5c: reload changed mid-count
    step(1, 1, 2, 1, "midrl_load");
    step(1, 0, 0, 0, "midrl_dec");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "midrl_term");

    // 5d: asynchronous reset mid-count
    step(1, 1, 6, 1, "areset_load");
    step(1, 0, 0, 1, "areset_dec");
    rst = 1'b0;
    model_reset();
    #2;
    sb_q.push_back('{cnt: '0, tc: 1'b0, busy: 1'b0});
    compare("areset_immediate");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, "areset_after");

`ifdef SYNCH_BIN_DOWN_COUNT_PRESCALE_EN
    // 6: prescaled count of 2
    step(1, 1, 2, 0, "presc_load");
    tc_seen = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "presc_run");
    check_count("presc_tc_pulses", tc_seen, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
